// File: rtl/irq_collector_pkg.sv
// Shared constants for the interrupt collector: register map, ACTIVE layout,
// bus widths and the source-count limit.
package irq_collector_pkg;

  localparam int N_IRQ_MAX        = 16;
  localparam int ADDR_W           = 3;
  localparam int DATA_W           = 16;
  localparam int IDX_W            = 4;
  localparam int ACTIVE_VALID_BIT = 15;

  localparam logic [ADDR_W-1:0] ADDR_PENDING  = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_EDGE_SEL = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_MASK0    = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_MASK1    = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_ACTIVE0  = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_ACTIVE1  = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_FORCE    = 3'd6;
  localparam logic [ADDR_W-1:0] ADDR_RAW      = 3'd7;

  // Build an ACTIVE register word: valid flag in the top bit, index in the low nibble.
  function automatic logic [DATA_W-1:0] pack_active(input logic valid,
                                                    input logic [IDX_W-1:0] idx);
    logic [DATA_W-1:0] r;
    r                   = '0;
    r[ACTIVE_VALID_BIT] = valid;
    r[IDX_W-1:0]        = idx;
    return r;
  endfunction

endpackage

// File: rtl/irq_collector_if.sv
// Avalon-MM slave bus of the interrupt collector.
interface irq_collector_if;
  import irq_collector_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (output address, chipselect, write_n, writedata,
                  input  readdata);
  modport slave  (input  address, chipselect, write_n, writedata,
                  output readdata);
endinterface

// File: rtl/irq_collector_prio_enc.sv
// Lowest-index-first priority encoder used to build the ACTIVE registers.
module irq_prio_enc
  import irq_collector_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]     vec,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan high to low so the lowest set bit is the last assignment to stick.
  always_comb begin
    valid = |vec;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/irq_collector.sv
// Interrupt collector: gathers level/edge sources into a pending register and
// routes them through two per-core masks to registered interrupt lines.
module irq_collector
  import irq_collector_pkg::*;
#(
  parameter int N_IRQ  = 8,
  parameter int N_CORE = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_IRQ-1:0]  irq_in,
  irq_collector_if.slave    bus,
  output logic [N_CORE-1:0] irq_out
);

  logic [N_IRQ-1:0]             irq_q, irq_d;
  logic [N_IRQ-1:0]             pending_q, pending_d;
  logic [N_IRQ-1:0]             edge_sel_q, edge_sel_d;
  logic [N_CORE-1:0][N_IRQ-1:0] mask_q, mask_d;
  logic [DATA_W-1:0]            readdata_q, readdata_d;
  logic [N_CORE-1:0]            irq_out_q, irq_out_d;

  logic                         wr_en;
  logic [N_IRQ-1:0]             wdata;
  logic [N_IRQ-1:0]             rise;
  logic [N_IRQ-1:0]             force_set;
  logic [N_IRQ-1:0]             pend_clr;
  logic [N_CORE-1:0][N_IRQ-1:0] pend_masked;
  logic [N_CORE-1:0]            act_vld;
  logic [N_CORE-1:0][IDX_W-1:0] act_idx;

  // Register bits at and above N_IRQ are simply dropped on write.
  logic unused_wdata_hi;
  assign unused_wdata_hi = ^bus.writedata;

  assign wr_en     = bus.chipselect & ~bus.write_n;
  assign wdata     = bus.writedata[N_IRQ-1:0];
  assign rise      = irq_in & ~irq_q;
  assign force_set = (wr_en && bus.address == ADDR_FORCE)   ? wdata : '0;
  assign pend_clr  = (wr_en && bus.address == ADDR_PENDING) ? wdata : '0;

  // One encoder per core over that core's view of pending.
  for (genvar c = 0; c < N_CORE; c++) begin : g_core
    assign pend_masked[c] = pending_q & mask_q[c];
    irq_prio_enc #(.N(N_IRQ)) u_enc (
      .vec   (pend_masked[c]),
      .valid (act_vld[c]),
      .idx   (act_idx[c])
    );
  end

  // Configuration registers: edge select and the per-core masks.
  always_comb begin
    irq_d      = irq_in;
    edge_sel_d = edge_sel_q;
    mask_d     = mask_q;
    if (wr_en && bus.address == ADDR_EDGE_SEL) edge_sel_d = wdata;
    for (int c = 0; c < N_CORE; c++) begin
      if (wr_en && bus.address == (ADDR_MASK0 + ADDR_W'(c))) mask_d[c] = wdata;
    end
  end

  // Pending: edge bits latch rise/force until cleared (set beats clear);
  // level bits track the input, with a force write adding a one-cycle pulse.
  always_comb begin
    pending_d = (edge_sel_q  & (rise | force_set | (pending_q & ~pend_clr)))
              | (~edge_sel_q & (irq_in | force_set));
  end

  // Core interrupt lines, one register stage after pending.
  always_comb begin
    irq_out_d = '0;
    for (int c = 0; c < N_CORE; c++) irq_out_d[c] = |pend_masked[c];
  end

  // Read mux, sampled every cycle regardless of chipselect.
  always_comb begin
    readdata_d = '0;
    case (bus.address)
      ADDR_PENDING:  readdata_d = DATA_W'(pending_q);
      ADDR_EDGE_SEL: readdata_d = DATA_W'(edge_sel_q);
      ADDR_MASK0:    readdata_d = DATA_W'(mask_q[0]);
      ADDR_MASK1:    readdata_d = DATA_W'(mask_q[1]);
      ADDR_ACTIVE0:  readdata_d = pack_active(act_vld[0], act_idx[0]);
      ADDR_ACTIVE1:  readdata_d = pack_active(act_vld[1], act_idx[1]);
      ADDR_FORCE:    readdata_d = '0;
      ADDR_RAW:      readdata_d = DATA_W'(irq_in);
      default:       readdata_d = '0;
    endcase
  end

  // State update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q      <= '0;
      pending_q  <= '0;
      edge_sel_q <= '0;
      mask_q     <= '0;
      readdata_q <= '0;
      irq_out_q  <= '0;
    end else begin
      irq_q      <= irq_d;
      pending_q  <= pending_d;
      edge_sel_q <= edge_sel_d;
      mask_q     <= mask_d;
      readdata_q <= readdata_d;
      irq_out_q  <= irq_out_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq_out      = irq_out_q;

endmodule

// File: tb/tb_irq_collector.sv
// Directed bench for irq_collector: inputs change on the falling edge,
// outputs are checked on the following falling edges.
module tb_irq_collector;
  import irq_collector_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq_in;
  logic [1:0] irq_out;

  int n_vec = 0;
  int n_err = 0;

  irq_collector_if bus ();

  irq_collector #(.N_IRQ(8), .N_CORE(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .irq_in  (irq_in),
    .bus     (bus),
    .irq_out (irq_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    step(1);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string tag);
    bus.address = a;
    step(1);
    chk(tag, bus.readdata, exp);
  endtask

  initial begin
    reset          = 1'b1;
    irq_in         = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = '0;
    bus.writedata  = '0;
    step(3);
    chk("rst_rdata", bus.readdata, 16'h0000);
    chk("rst_irq_out", {14'b0, irq_out}, 16'h0000);
    reset = 1'b0;
    step(1);
    rd(ADDR_MASK0, 16'h0000, "rst_mask0");
    rd(ADDR_PENDING, 16'h0000, "rst_pend");

    // write strobe without chipselect must not land
    bus.address   = ADDR_MASK1;
    bus.writedata = 16'hFFFF;
    bus.write_n   = 1'b0;
    step(1);
    bus.write_n   = 1'b1;
    rd(ADDR_MASK1, 16'h0000, "nocs_write");

    // level source 0 through core 0
    wr(ADDR_MASK0, 16'h0001);
    irq_in[0]   = 1'b1;
    bus.address = ADDR_ACTIVE0;
    step(1);
    chk("lvl_out_t1", {14'b0, irq_out}, 16'h0000);
    step(1);
    chk("lvl_out_t2", {14'b0, irq_out}, 16'h0001);
    chk("lvl_active0", bus.readdata, 16'h8000);
    irq_in[0] = 1'b0;
    step(1);
    chk("lvl_drop_t1", {14'b0, irq_out}, 16'h0001);
    step(1);
    chk("lvl_drop_t2", {14'b0, irq_out}, 16'h0000);

    // edge source 2 through core 1, write-1-to-clear
    wr(ADDR_EDGE_SEL, 16'h0004);
    wr(ADDR_MASK1, 16'h0004);
    irq_in[2] = 1'b1;
    step(1);
    irq_in[2] = 1'b0;
    step(1);
    chk("edge_out", {14'b0, irq_out}, 16'h0002);
    rd(ADDR_PENDING, 16'h0004, "edge_pend_held");
    chk("edge_out_held", {14'b0, irq_out}, 16'h0002);
    wr(ADDR_PENDING, 16'h0004);
    chk("w1c_out_t1", {14'b0, irq_out}, 16'h0002);
    step(1);
    chk("w1c_out_t2", {14'b0, irq_out}, 16'h0000);

    // rise and clear of source 3 in the same cycle: set wins
    wr(ADDR_EDGE_SEL, 16'h000C);
    irq_in[3] = 1'b1;
    wr(ADDR_PENDING, 16'h0008);
    irq_in[3] = 1'b0;
    rd(ADDR_PENDING, 16'h0008, "collision_pend");
    wr(ADDR_PENDING, 16'h0008);
    rd(ADDR_PENDING, 16'h0000, "collision_clr");

    // priority among sources 5 and 7 on core 0
    wr(ADDR_MASK1, 16'h0000);
    wr(ADDR_MASK0, 16'h00F0);
    irq_in = 8'hA0;
    step(1);
    rd(ADDR_ACTIVE0, 16'h8005, "prio_active0");
    chk("prio_out", {14'b0, irq_out}, 16'h0001);
    rd(ADDR_PENDING, 16'h00A0, "multi_pend");
    rd(ADDR_ACTIVE1, 16'h0000, "active1_none");
    wr(ADDR_MASK0, 16'h0000);
    chk("mask_chg_t1", {14'b0, irq_out}, 16'h0001);
    step(1);
    chk("mask_chg_t2", {14'b0, irq_out}, 16'h0000);
    rd(ADDR_PENDING, 16'h00A0, "mask_keeps_pend");
    irq_in = 8'h00;
    step(2);

    // force on source 1 through core 1, raw input readback
    wr(ADDR_MASK1, 16'h0002);
    wr(ADDR_FORCE, 16'h0002);
    chk("force_out_t1", {14'b0, irq_out}, 16'h0000);
    step(1);
    chk("force_out_t2", {14'b0, irq_out}, 16'h0002);
    rd(ADDR_RAW, 16'h0000, "raw_zero");
    irq_in = 8'h81;
    rd(ADDR_RAW, 16'h0081, "raw_val");
    irq_in = 8'h00;
    step(2);

    // reset in the middle of activity
    wr(ADDR_EDGE_SEL, 16'h00FF);
    wr(ADDR_FORCE, 16'h00FF);
    rd(ADDR_PENDING, 16'h00FF, "pre_rst_pend");
    reset       = 1'b1;
    irq_in      = 8'h02;
    bus.address = ADDR_PENDING;
    step(1);
    chk("rst_mid_rdata", bus.readdata, 16'h0000);
    chk("rst_mid_out", {14'b0, irq_out}, 16'h0000);
    reset = 1'b0;
    step(1);
    chk("rst_rel_t1", bus.readdata, 16'h0000);
    step(1);
    chk("rst_rel_t2", bus.readdata, 16'h0002);
    rd(ADDR_EDGE_SEL, 16'h0000, "rst_edge_sel");
    rd(ADDR_MASK0, 16'h0000, "rst_mask0_b");
    rd(ADDR_MASK1, 16'h0000, "rst_mask1_b");
    rd(ADDR_ACTIVE0, 16'h0000, "rst_active0");

    // bits above N_IRQ ignore writes
    wr(ADDR_MASK0, 16'hFFFF);
    rd(ADDR_MASK0, 16'h00FF, "mask_wide");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
